csr_trap_unit: RTL
==================

// Module: csr_trap_unit
// PURPOSE
//  Machine-mode CSR file plus trap/return sequencer. Sits downstream of the exception priority stage:
//  - takes the selected trap (cause, faulting PC, tval) and commits mepc/mcause/mtval/mstatus
//  - redirects fetch to mtvec; executes MRET
//  - serves CSR instructions from EX
//  - keeps the mcycle/minstret counters
// PARAMETERS
//  MTVEC_RESET  32'h0000_0100  reset value of mtvec (direct mode, low 2 bits forced 0)
//  MISA_VALUE   32'h4000_0100  read-only misa contents (RV32I)
// PORTS
//  clk_i            in   1   clock
//  rst_i            in   1   synchronous active-high reset
//  trap_valid_i     in   1   trap request from exception stage (one-cycle pulse)
//  trap_cause_i     in   32  mcause value to record
//  trap_pc_i        in   32  PC of faulting instruction
//  trap_tval_i      in   32  mtval value to record
//  mret_i           in   1   MRET retiring this cycle
//  csr_req_i        in   1   CSR instruction access valid
//  csr_op_i         in   2   csr_op_e: RW=0, RS=1, RC=2; 3 is illegal
//  csr_we_i         in   1   access writes (0 for RS/RC with rs1=x0)
//  csr_addr_i       in   12  CSR address
//  csr_wdata_i      in   32  operand (rs1/zimm)
//  csr_rdata_o      out  32  old CSR value (combinational)
//  csr_illegal_o    out  1   access illegal (combinational)
//  instr_retire_i   in   1   one instruction retired this cycle
//  redirect_valid_o out  1   PC redirect pulse
//  redirect_pc_o    out  32  redirect target
//  flush_o          out  1   flush IF/ID/EX
//  busy_o           out  1   unit in TRAP_COMMIT; upstream stalls
// BEHAVIOUR
//  Reset:
//   - redirect_valid_o=0, flush_o=0, busy_o=0, redirect_pc_o=0, state=IDLE
//   - mstatus.MIE=MPIE=0; mtvec=MTVEC_RESET; mscratch/mepc/mcause/mtval=0; counters=0
//   - reset mid-trap abandons the commit: no CSR update, no redirect
//  FSM IDLE/TRAP_COMMIT:
//   - IDLE + trap_valid_i: latch cause/pc/tval, flush_o=1, next state TRAP_COMMIT
//   - TRAP_COMMIT (exactly 1 cycle), in the same cycle:
//     - write mepc=pc&~3, mcause, mtval; MPIE<=MIE, MIE<=0
//     - redirect_valid_o=1, redirect_pc_o={mtvec[31:2],2'b00}, flush_o=1, busy_o=1
//     - then IDLE
//   - Trap latency: request edge -> redirect at +1 cycle.
//  MRET (IDLE, no trap):
//   - next cycle redirect_valid_o=1, redirect_pc_o=mepc, flush_o=1
//   - MIE<=MPIE, MPIE<=1; state stays IDLE
//  Same-cycle priority: trap > mret > CSR write (lower ones dropped).
//   - In TRAP_COMMIT all trap/mret/csr inputs are ignored.
//  CSR map (anything else illegal):
//   - 0x300 mstatus: MIE b3, MPIE b7; MPP[12:11] reads 2'b11; other bits read 0
//   - 0x301 misa: RO
//   - 0x305 mtvec: bits[1:0] read 0
//   - 0x340 mscratch
//   - 0x341 mepc: bits[1:0] read 0
//   - 0x342 mcause
//   - 0x343 mtval
//   - 0xB00/0xB80 mcycle lo/hi
//   - 0xB02/0xB82 minstret lo/hi
//   - 0xF14 mhartid: RO 0
//  CSR access rules:
//   - Write value: RW=wdata, RS=old|wdata, RC=old&~wdata; committed at next edge.
//   - Illegal if: address unmapped, csr_op_i=3, or csr_we_i=1 to a RO CSR (0x301, 0xF14).
//   - Illegal access writes nothing; csr_rdata_o=0.
//  Counters:
//   - mcycle +1 every cycle; minstret +1 per instr_retire_i; both wrap 2^64-1 -> 0
//   - CSR write to a half in the same cycle wins over the increment for that cycle (whole counter)
//   - a trap/mret redirect cycle does not block counting
// STRUCTURE
//  Shared package additions:
//   - CSR_MSTATUS..CSR_MHARTID address constants
//   - csr_op_e
//   - trap_state_e {IDLE, TRAP_COMMIT}
//   - MSTATUS_MIE_BIT=3, MSTATUS_MPIE_BIT=7
//  One sub-module: csr_counter64 (64-bit counter, inc_i, lo/hi write ports, write-wins), instantiated twice.
// TESTING
//  1 Reset, read mtvec -> 0x100; mstatus -> 0x1800; mcycle_lo counts 1,2,3 after release.
//  2 MIE=1, trap cause=2 pc=0x1002 tval=0xDEAD ->
//    - +1 cycle: redirect 0x100, busy=1
//    - mepc=0x1000, mcause=2, mtval=0xDEAD, mstatus=0x1880
//  3 After test 2, mret -> next cycle redirect to 0x1000, MIE=1, MPIE=1.
//  4 CSRRS 0x340 with 0xF0 on mscratch=0x0F -> rdata 0x0F, then 0xFF.
//    CSRRW to 0xF14 with we=1 -> illegal, no change.
//  5 trap+mret+csr write in same cycle -> only the trap commits; mepc unchanged by mret; CSR unchanged.
//  6 mcycle=0xFFFF_FFFF_FFFF_FFFF -> wraps to 0.
//    Write mcycle_lo=5 in a counting cycle -> reads 5, then 6.

Source files
------------

// File: rtl/csr_trap_unit_pkg.sv
// Shared types and constants for the machine-mode CSR file and trap sequencer.
package csr_trap_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    // MPP is hardwired to machine mode.
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;

    typedef enum logic [1:0] {
        CSR_RW = 2'd0,
        CSR_RS = 2'd1,
        CSR_RC = 2'd2
    } csr_op_e;

    typedef enum logic {
        IDLE        = 1'b0,
        TRAP_COMMIT = 1'b1
    } trap_state_e;

    // New CSR value for a read-modify-write access.
    function automatic logic [31:0] csr_apply(input csr_op_e op,
                                              input logic [31:0] old_v,
                                              input logic [31:0] operand);
        case (op)
            CSR_RW:  return operand;
            CSR_RS:  return old_v | operand;
            CSR_RC:  return old_v & ~operand;
            default: return old_v;
        endcase
    endfunction

endpackage

// File: rtl/csr_trap_unit_counter64.sv
// 64-bit free-running counter with 32-bit half write ports; a write beats the increment.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [63:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (wr_lo_i) begin
            r_count <= {r_count[63:32], wdata_i};
        end else if (wr_hi_i) begin
            r_count <= {wdata_i, r_count[31:0]};
        end else if (inc_i) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign value_o = r_count;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry / MRET sequencing and mcycle/minstret counters.
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trap_valid_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_tval_i,
    input  logic        mret_i,
    input  logic        csr_req_i,
    input  logic [1:0]  csr_op_i,
    input  logic        csr_we_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    input  logic        instr_retire_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        busy_o
);

    trap_state_e r_state;
    logic [31:0] r_trap_cause;
    logic [31:0] r_trap_pc;
    logic [31:0] r_trap_tval;
    logic        r_mie;
    logic        r_mpie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;
    logic        r_flush;
    logic        r_busy;

    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic [31:0] w_mstatus;
    logic [31:0] w_old;
    logic        w_hit;
    logic        w_ro;
    logic        w_illegal;
    logic        w_idle;
    logic        w_wr_en;
    logic [31:0] w_wdata;

    assign w_idle = (r_state == IDLE);

    // Read mux and address decode.
    always_comb begin
        w_mstatus                   = MSTATUS_FIXED;
        w_mstatus[MSTATUS_MIE_BIT]  = r_mie;
        w_mstatus[MSTATUS_MPIE_BIT] = r_mpie;
        w_old = '0;
        w_hit = 1'b1;
        w_ro  = 1'b0;
        case (csr_addr_i)
            CSR_MSTATUS:   w_old = w_mstatus;
            CSR_MISA:      begin w_old = MISA_VALUE; w_ro = 1'b1; end
            CSR_MTVEC:     w_old = r_mtvec;
            CSR_MSCRATCH:  w_old = r_mscratch;
            CSR_MEPC:      w_old = r_mepc;
            CSR_MCAUSE:    w_old = r_mcause;
            CSR_MTVAL:     w_old = r_mtval;
            CSR_MCYCLE:    w_old = w_mcycle[31:0];
            CSR_MCYCLEH:   w_old = w_mcycle[63:32];
            CSR_MINSTRET:  w_old = w_minstret[31:0];
            CSR_MINSTRETH: w_old = w_minstret[63:32];
            CSR_MHARTID:   w_ro  = 1'b1;
            default:       w_hit = 1'b0;
        endcase
    end

    assign w_illegal     = !w_hit || (csr_op_i == 2'd3) || (csr_we_i && w_ro);
    assign csr_illegal_o = csr_req_i && w_illegal;
    assign csr_rdata_o   = (csr_req_i && !w_illegal) ? w_old : 32'h0;
    assign w_wdata       = csr_apply(csr_op_e'(csr_op_i), w_old, csr_wdata_i);

    // A CSR write only lands when neither a trap nor an MRET claims the cycle.
    assign w_wr_en = w_idle && !trap_valid_i && !mret_i
                     && csr_req_i && csr_we_i && !w_illegal;

    csr_counter64 u_mcycle (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (1'b1),
        .wr_lo_i (w_wr_en && (csr_addr_i == CSR_MCYCLE)),
        .wr_hi_i (w_wr_en && (csr_addr_i == CSR_MCYCLEH)),
        .wdata_i (w_wdata),
        .value_o (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (instr_retire_i),
        .wr_lo_i (w_wr_en && (csr_addr_i == CSR_MINSTRET)),
        .wr_hi_i (w_wr_en && (csr_addr_i == CSR_MINSTRETH)),
        .wdata_i (w_wdata),
        .value_o (w_minstret)
    );

    // Trap/return sequencer and CSR state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state          <= IDLE;
            r_trap_cause     <= '0;
            r_trap_pc        <= '0;
            r_trap_tval      <= '0;
            r_mie            <= 1'b0;
            r_mpie           <= 1'b0;
            r_mtvec          <= MTVEC_RESET & ~32'h3;
            r_mscratch       <= '0;
            r_mepc           <= '0;
            r_mcause         <= '0;
            r_mtval          <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_redirect_valid <= 1'b0;
            r_flush          <= 1'b0;
            r_busy           <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (trap_valid_i) begin
                        r_trap_cause     <= trap_cause_i;
                        r_trap_pc        <= trap_pc_i & ~32'h3;
                        r_trap_tval      <= trap_tval_i;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= r_mtvec;
                        r_flush          <= 1'b1;
                        r_busy           <= 1'b1;
                        r_state          <= TRAP_COMMIT;
                    end else if (mret_i) begin
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= r_mepc;
                        r_flush          <= 1'b1;
                        r_mie            <= r_mpie;
                        r_mpie           <= 1'b1;
                    end else if (w_wr_en) begin
                        case (csr_addr_i)
                            CSR_MSTATUS: begin
                                r_mie  <= w_wdata[MSTATUS_MIE_BIT];
                                r_mpie <= w_wdata[MSTATUS_MPIE_BIT];
                            end
                            CSR_MTVEC:    r_mtvec    <= w_wdata & ~32'h3;
                            CSR_MSCRATCH: r_mscratch <= w_wdata;
                            CSR_MEPC:     r_mepc     <= w_wdata & ~32'h3;
                            CSR_MCAUSE:   r_mcause   <= w_wdata;
                            CSR_MTVAL:    r_mtval    <= w_wdata;
                            default:      ;
                        endcase
                    end
                end
                TRAP_COMMIT: begin
                    r_mepc   <= r_trap_pc;
                    r_mcause <= r_trap_cause;
                    r_mtval  <= r_trap_tval;
                    r_mpie   <= r_mie;
                    r_mie    <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign redirect_valid_o = r_redirect_valid;
    assign redirect_pc_o    = r_redirect_pc;
    assign flush_o          = r_flush;
    assign busy_o           = r_busy;

endmodule
